alu_sll: RTL and testbench



---
 rtl/alu_sll.sv | 105 ++++++++++
 tb/tb_alu_sll.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/alu_sll.sv
// alu_sll: RV32I shift-left-logical unit (SLL/SLLI) for the integer ALU.
//
// rd = rs1 << rs2[SHAMT_W-1:0]. Vacated LSBs are zero-filled, and bits shifted
// past the MSB are discarded. The shifter is an explicit log2 barrel. Stage k
// moves the word left by 2^k when shamt[k] is set. The result is registered
// and marked with a valid strobe.
//
// Optional build macro: ALU_SLL_PIPE_EN
//   undefined : stages 0..SHAMT_W-1 are combinational in front of the output
//               register, so latency is 1 cycle.
//   defined   : a register is placed after stage 2. It holds the partial
//               shift, the still-unused upper shamt bits and a valid bit.
//               Latency is 2 cycles, and throughput stays one per cycle.
//
// Valid semantics: in_valid marks rs1/rs2 as one operation on the posedge where
// it is sampled high. out_valid is high for exactly one cycle per accepted
// operation, at a fixed latency. There is no ready/backpressure, so the
// consumer must take rd whenever out_valid=1. rst has priority over in_valid,
// and it drops any operation still inside the unit.

module alu_sll #(
  parameter int XLEN    = 32,
  parameter int SHAMT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            out_valid,
  output logic [XLEN-1:0] rd
);

  // Number of barrel stages that sit in front of the optional pipeline cut.
  // Stages 0..SPLIT-1 form the front half, and SPLIT..SHAMT_W-1 the back half.
  localparam int SPLIT = 3;

  // Shift amount. The upper rs2 bits carry no meaning for SLL and are dropped.
  logic [SHAMT_W-1:0] shamt;
  logic               unused_rs2_hi;

  assign shamt         = rs2[SHAMT_W-1:0];
  assign unused_rs2_hi = ^rs2[XLEN-1:SHAMT_W];

  // Front half of the barrel: front[0] is rs1, and front[k+1] is the output of stage k.
  logic [XLEN-1:0] front [0:SPLIT];

  assign front[0] = rs1;

  for (genvar k = 0; k < SPLIT; k++) begin : g_front
    localparam int SH = 1 << k;
    assign front[k+1] = shamt[k] ? {front[k][XLEN-1-SH:0], {SH{1'b0}}}
                                 : front[k];
  end

  // Boundary between the halves. The back half reads only these signals.
  logic [XLEN-1:0]          mid_data;
  logic [SHAMT_W-1:SPLIT]   mid_hi;
  logic                     mid_valid;

`ifdef ALU_SLL_PIPE_EN
  // Pipeline cut after stage SPLIT-1: capture the partial shift, the remaining shamt bits and the valid bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      mid_data  <= '0;
      mid_hi    <= '0;
      mid_valid <= 1'b0;
    end else begin
      mid_data  <= front[SPLIT];
      mid_hi    <= shamt[SHAMT_W-1:SPLIT];
      mid_valid <= in_valid;
    end
  end
`else
  // No cut: the back half follows the front half within the same cycle.
  assign mid_data  = front[SPLIT];
  assign mid_hi    = shamt[SHAMT_W-1:SPLIT];
  assign mid_valid = in_valid;
`endif

  // Back half of the barrel: back[SPLIT] is mid_data, and back[k+1] is the output of stage k.
  logic [XLEN-1:0] back [SPLIT:SHAMT_W];

  assign back[SPLIT] = mid_data;

  for (genvar k = SPLIT; k < SHAMT_W; k++) begin : g_back
    localparam int SH = 1 << k;
    assign back[k+1] = mid_hi[k] ? {back[k][XLEN-1-SH:0], {SH{1'b0}}}
                                 : back[k];
  end

  // Output register: load the result on a valid op; when idle, keep rd and drop the strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      rd        <= '0;
    end else begin
      out_valid <= mid_valid;
      if (mid_valid) begin
        rd <= back[SHAMT_W];
      end
    end
  end

endmodule

// File: tb/tb_alu_sll.sv
// tb_alu_sll: directed and randomized bench for alu_sll.
// The reference model computes rs1 << rs2[4:0] arithmetically. It times
// out_valid from the build's latency and matches results in order through an
// expected queue. Build macro: ALU_SLL_PIPE_EN selects a latency of 2 instead of 1.

module tb_alu_sll;

`ifdef ALU_SLL_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [31:0] rs1;
  logic [31:0] rs2;
  logic        out_valid;
  logic [31:0] rd;

  alu_sll #(.XLEN(32), .SHAMT_W(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .rs1       (rs1),
    .rs2       (rs2),
    .out_valid (out_valid),
    .rd        (rd)
  );

  // Clock and reset.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard state.
  logic [31:0] exp_q[$];
  logic        vq [0:LAT-1];
  logic [31:0] exp_rd;
  int          checks;
  int          errors;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Driver: apply one cycle of inputs, advance the model, then check the outputs 1ns after the edge.
  task automatic step(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b);
    rst      = r;
    in_valid = v;
    rs1      = a;
    rs2      = b;
    @(posedge clk);
    if (r) begin
      for (int i = 0; i < LAT; i++) vq[i] = 1'b0;
      exp_q.delete();
      exp_rd = 32'h0;
    end else begin
      for (int i = LAT - 1; i > 0; i--) vq[i] = vq[i-1];
      vq[0] = v;
      if (v) exp_q.push_back(a << b[4:0]);
    end
    #1;
    check("out_valid", {31'b0, out_valid}, {31'b0, vq[LAT-1]});
    if (vq[LAT-1]) begin
      if (exp_q.size() == 0) begin
        check("queue_underflow", 32'd0, 32'd1);
      end else begin
        exp_rd = exp_q.pop_front();
      end
    end
    check("rd", rd, exp_rd);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, $urandom, $urandom);
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    exp_rd   = 32'h0;
    rst      = 1'b1;
    in_valid = 1'b0;
    rs1      = 32'h0;
    rs2      = 32'h0;
    for (int i = 0; i < LAT; i++) vq[i] = 1'b0;

    // Reset for two cycles, then stay idle.
    step(1'b1, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b1, 32'hDEAD_BEEF, 32'h4);
    idle(3);

    // Directed patterns, including the shamt boundaries and the rs2 upper-bit aliasing.
    step(1'b0, 1'b1, 32'h0000_0001, 32'd1);
    idle(LAT + 1);
    step(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3);
    step(1'b0, 1'b1, 32'h0000_0000, 32'd1);
    step(1'b0, 1'b1, 32'h8000_0001, 32'd0);
    step(1'b0, 1'b1, 32'h8000_0001, 32'd31);
    step(1'b0, 1'b1, 32'h8000_0001, 32'd33);
    step(1'b0, 1'b1, 32'h0000_0000, 32'd17);
    step(1'b0, 1'b1, 32'h1234_5678, 32'hFFFF_FFE4);
    idle(LAT + 2);

    // Four back-to-back ops, then reset on the following cycle.
    step(1'b0, 1'b1, 32'h0000_00A5, 32'd4);
    step(1'b0, 1'b1, 32'h0F0F_0F0F, 32'd8);
    step(1'b0, 1'b1, 32'hCAFE_F00D, 32'd12);
    step(1'b0, 1'b1, 32'h7777_7777, 32'd2);
    step(1'b1, 1'b0, 32'h0, 32'h0);
    idle(LAT + 2);

    // Randomized traffic, with an occasional reset.
    for (int i = 0; i < 400; i++) begin
      logic        r;
      logic        v;
      logic [31:0] a;
      logic [31:0] b;
      r = ($urandom_range(0, 40) == 0);
      v = ($urandom_range(0, 3) != 0);
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 7) == 0) a = 32'h0;
      if ($urandom_range(0, 7) == 0) b = {b[31:5], 5'd31};
      step(r, v, a, b);
    end
    idle(LAT + 2);

    check("queue_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
